// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the nibble-serial ripple-carry sequencer.
// Build option: RCA_SEQ_SUB_EN adds a subtract mode to rca_seq_ctrl.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    // Nibble counter width: ceil(log2(nibbles)), never narrower than one bit.
    function automatic int cnt_w(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/rca_seq_nib_sel.sv
// Selects nibble 'sel' out of a NIBBLES*4-bit register; one copy per operand.
module rca_seq_nib_sel
    import rca_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic [NIBBLES*NIBBLE_W-1:0] data,
    input  logic [cnt_w(NIBBLES)-1:0]   sel,
    output logic [NIBBLE_W-1:0]         nib
);

    always_comb begin
        nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (int'(sel) == i) begin
                nib = data[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide add (4*NIBBLES bits) done LSB-first, one nibble per clock, on an external 4-bit slice.
// Build option: RCA_SEQ_SUB_EN adds the 'sub' port (a - b via ~b and carry-in 1).
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NIBBLES*NIBBLE_W-1:0] a,
    input  logic [NIBBLES*NIBBLE_W-1:0] b,
    input  logic                        cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                        sub,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLES*NIBBLE_W-1:0] sum,
    output logic                        cout,
    output logic [NIBBLE_W-1:0]         add_i0,
    output logic [NIBBLE_W-1:0]         add_i1,
    output logic                        add_cin,
    input  logic [NIBBLE_W-1:0]         add_o,
    input  logic                        add_cout
);

    localparam int W  = NIBBLES * NIBBLE_W;
    localparam int KW = cnt_w(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    // Operand slices come straight from registers so the adder sees stable inputs all cycle.
    rca_seq_nib_sel #(.NIBBLES(NIBBLES)) u_sel_a (
        .data (a_q),
        .sel  (k_q),
        .nib  (add_i0)
    );

    rca_seq_nib_sel #(.NIBBLES(NIBBLES)) u_sel_b (
        .data (b_q),
        .sel  (k_q),
        .nib  (add_i1)
    );

    assign add_cin = carry_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = a;
`ifdef RCA_SEQ_SUB_EN
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = b;
                        carry_d = cin;
                    end
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    k_d     = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Only the current nibble is rewritten; the rest keep the previous result.
                for (int i = 0; i < NIBBLES; i++) begin
                    if (int'(k_q) == i) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = add_o;
                    end
                end
                carry_d = add_cout;
                if (k_q == K_LAST) begin
                    cout_d  = add_cout;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl (NIBBLES=4) with a behavioural 4-bit adder slice on the add_* loop.
module tb_rca_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 16;
`ifdef RCA_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  a, b;
    logic          cin;
`ifdef RCA_SEQ_SUB_EN
    logic          sub;
`endif
    logic          busy, done, cout;
    logic [W-1:0]  sum;
    logic [3:0]    add_i0, add_i1, add_o;
    logic          add_cin, add_cout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // External 4-bit slice.
    assign {add_cout, add_o} = {1'b0, add_i0} + {1'b0, add_i1} + {4'b0000, add_cin};

    rca_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_i0   (add_i0),
        .add_i1   (add_i1),
        .add_cin  (add_cin),
        .add_o    (add_o),
        .add_cout (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cout,sum} of the whole operation.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        if (s && SUB_EN) return {1'b0, x} + {1'b0, ~y} + 17'd1;
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    // Carry entering nibble j: carry out of the low 4*j bits of the effective sum.
    function automatic logic carry_in(input logic [15:0] x, input logic [15:0] y,
                                      input logic c, input logic s, input int j);
        logic [31:0] m, ye, t;
        logic        ce;
        ye = (s && SUB_EN) ? {16'd0, ~y} : {16'd0, y};
        ce = (s && SUB_EN) ? 1'b1 : c;
        m  = (32'd1 << (4 * j)) - 32'd1;
        t  = ({16'd0, x} & m) + (ye & m) + {31'd0, ce};
        return t[4*j];
    endfunction

    task automatic scramble();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
        sub = 1'($urandom);
`endif
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                         input logic ts, input bit poke);
        logic [16:0] exp;
        int          n;
        int          extra;
        exp = model(ta, tbv, tc, ts);
        @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
`ifdef RCA_SEQ_SUB_EN
        sub = ts;
`endif
        @(negedge clk);
        scramble();
        if (poke) begin
            start = 1'b1;
            a     = 16'hAAAA;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            chk("busy_run", 32'(busy), 32'd1);
            if (n < NIB) begin
                chk("add_cin", 32'(add_cin), 32'(carry_in(ta, tbv, tc, ts, n)));
                chk("add_i0", 32'(add_i0), 32'(ta[4*n +: 4]));
            end
            n++;
            @(negedge clk);
            scramble();
            if (poke) a = 16'hAAAA;
        end
        chk("latency", 32'(n), 32'(NIB));
        chk("sum", 32'(sum), 32'(exp[15:0]));
        chk("cout", 32'(cout), 32'(exp[16]));
        chk("busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("no_extra_done", 32'(extra), 32'd0);
        chk("sum_hold", 32'(sum), 32'(exp[15:0]));
        chk("cout_hold", 32'(cout), 32'(exp[16]));
    endtask

    initial begin
        int dn;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_i0", 32'(add_i0), 32'd0);
        chk("rst_i1", 32'(add_i1), 32'd0);
        chk("rst_cin", 32'(add_cin), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
        do_op(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);

        // Abort mid-operation with reset at k=2.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
`ifdef RCA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_i0", 32'(add_i0), 32'd0);
        chk("abort_cin", 32'(add_cin), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        do_op(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);

        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);

        repeat (20) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
